// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Imported by the byte packer and the top-level sequencer.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {RUN, LOAD, FLUSH, DONE} imem_state_t;

  localparam logic [31:0] NOP_INSN   = 32'h00000013;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs loader bytes little-endian into 32-bit words. Flags the byte that
// completes a word; unfilled upper lanes read as zero for a partial flush.
module imem_byte_packer
  import imem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic        word_full,
  output logic [31:0] word
);

  logic [23:0] lanes;

  assign word_full = accept && (byte_cnt == 2'(WORD_BYTES - 1));
  // The completing byte bypasses the lanes so the word is written in the same cycle.
  assign word      = {word_full ? byte_in : 8'h00, lanes};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear || word_full) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (accept) begin
      lanes[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt                       <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single instruction-memory port between core fetch and a
// byte-serial program loader; the core is stalled for the whole load session.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          DEPTH = 32,
  parameter logic [31:0] NOP   = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        core_stall,
  input  logic        ld_start,
  input  logic        ld_byte_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        ld_ready,
  output logic        ld_done,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  imem_state_t       state, state_next;
  logic [PTR_W-1:0]  word_ptr;
  logic [1:0]        byte_cnt;
  logic              accept, word_full, in_range, last_word, cnt_zero_after;
  logic [31:0]       packed_word, word_addr;

  assign accept         = (state == LOAD) && ld_byte_valid;
  assign in_range       = fetch_addr[31:2] < 30'(DEPTH);
  assign last_word      = word_ptr == PTR_W'(DEPTH - 1);
  assign word_addr      = 32'({word_ptr, 2'b00});
  // Byte count as it will be after this cycle's byte, used to route ld_end.
  assign cnt_zero_after = word_full || (byte_cnt == 2'd0 && !accept);

  imem_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == DONE),
    .accept   (accept),
    .byte_in  (ld_byte),
    .byte_cnt (byte_cnt),
    .word_full(word_full),
    .word     (packed_word)
  );

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    fetch_gnt  = 1'b0;
    core_stall = 1'b1;
    ld_ready   = 1'b0;
    ld_done    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      RUN: begin
        core_stall = 1'b0;
        fetch_gnt  = fetch_req;
        if (fetch_req && in_range) mem_addr = fetch_addr;
        if (ld_start) state_next = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (word_full) begin
          mem_we    = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = packed_word;
        end
        if (word_full && last_word) state_next = DONE;
        else if (ld_end)            state_next = cnt_zero_after ? DONE : FLUSH;
      end
      FLUSH: begin
        mem_we     = 1'b1;
        mem_addr   = word_addr;
        mem_wdata  = packed_word;
        state_next = DONE;
      end
      DONE: begin
        ld_done    = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    // Reset is asynchronous, so the combinational outputs must be quiet while it is held.
    if (rst) begin
      fetch_gnt  = 1'b0;
      core_stall = 1'b0;
      ld_ready   = 1'b0;
      ld_done    = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      word_ptr    <= '0;
      fetch_valid <= 1'b0;
      fetch_inst  <= '0;
    end else begin
      state       <= state_next;
      fetch_valid <= fetch_gnt;
      if (fetch_gnt) fetch_inst <= in_range ? mem_rdata : NOP;
      if (state == DONE)                     word_ptr <= '0;
      else if (word_full && !last_word)      word_ptr <= word_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a behavioural combinational-read
// instruction memory attached to the memory port.
module tb_imem_access_ctrl;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt, fetch_valid, core_stall;
  logic [31:0] fetch_inst;
  logic        ld_start, ld_byte_valid, ld_end, ld_ready, ld_done;
  logic [7:0]  ld_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [DEPTH];
  int          zero_writes = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  imem_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_valid  (fetch_valid),
    .fetch_inst   (fetch_inst),
    .core_stall   (core_stall),
    .ld_start     (ld_start),
    .ld_byte_valid(ld_byte_valid),
    .ld_byte      (ld_byte),
    .ld_end       (ld_end),
    .ld_ready     (ld_ready),
    .ld_done      (ld_done),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
      if (mem_addr == 32'h0) zero_writes++;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ld_start = 1'b0; ld_end = 1'b0; ld_byte_valid = 1'b0; fetch_req = 1'b0;
    #1;
  endtask

  task automatic start_load();
    @(negedge clk);
    ld_start = 1'b1; ld_end = 1'b0; ld_byte_valid = 1'b0; fetch_req = 1'b0;
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    ld_start = 1'b0; ld_end = 1'b0; ld_byte_valid = 1'b1; ld_byte = b;
    #1;
  endtask

  task automatic end_load();
    @(negedge clk);
    ld_start = 1'b0; ld_end = 1'b1; ld_byte_valid = 1'b0;
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = addr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int zw;
    logic exp_we;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hdead0000 + 32'(i);
    mem[3] = 32'h00a00113;
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hC;
    ld_start = 1'b0; ld_byte_valid = 1'b0; ld_byte = 8'h00; ld_end = 1'b0;

    // Reset state, with a fetch request held to show the grant is suppressed
    #2;
    check("rst_gnt", fetch_gnt, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_stall", core_stall, 0);
    check("rst_valid", fetch_valid, 0);
    check("rst_inst", fetch_inst, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", ld_done, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; fetch_req = 1'b0;

    // 1: in-range fetch, 1-cycle latency
    fetch(32'hC);
    check("t1_gnt", fetch_gnt, 1);
    check("t1_addr", mem_addr, 32'hC);
    @(posedge clk); #1;
    check("t1_valid", fetch_valid, 1);
    check("t1_inst", fetch_inst, 32'h00a00113);

    // 2: out-of-range fetch returns NOP without a memory access
    fetch(32'h80);
    check("t2_gnt", fetch_gnt, 1);
    check("t2_we", mem_we, 0);
    check("t2_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("t2_valid", fetch_valid, 1);
    check("t2_inst", fetch_inst, 32'h00000013);
    idle();
    @(posedge clk); #1;
    check("t2_valid_drop", fetch_valid, 0);

    // 3: two full words then ld_end with nothing pending
    start_load();
    check("t3_stall_start", core_stall, 0);
    drive_byte(8'hb7);
    check("t3_stall", core_stall, 1);
    check("t3_ready", ld_ready, 1);
    check("t3_gnt_blocked", fetch_gnt, 0);
    drive_byte(8'h50);
    drive_byte(8'h34);
    check("t3_we_b2", mem_we, 0);
    drive_byte(8'h12);
    check("t3_we_w0", mem_we, 1);
    check("t3_addr_w0", mem_addr, 32'h0);
    check("t3_data_w0", mem_wdata, 32'h123450b7);
    drive_byte(8'h17);
    check("t3_we_b4", mem_we, 0);
    drive_byte(8'h51);
    drive_byte(8'h34);
    drive_byte(8'h12);
    check("t3_we_w1", mem_we, 1);
    check("t3_addr_w1", mem_addr, 32'h4);
    check("t3_data_w1", mem_wdata, 32'h12345117);
    end_load();
    check("t3_end_we", mem_we, 0);
    check("t3_end_stall", core_stall, 1);
    idle();
    check("t3_done", ld_done, 1);
    check("t3_done_stall", core_stall, 1);
    check("t3_done_ready", ld_ready, 0);
    idle();
    check("t3_done_pulse", ld_done, 0);
    check("t3_run_stall", core_stall, 0);
    check("t3_mem0", mem[0], 32'h123450b7);
    check("t3_mem1", mem[1], 32'h12345117);
    fetch(32'h4);
    @(posedge clk); #1;
    check("t3_fetch_loaded", fetch_inst, 32'h12345117);

    // 4: partial word flushed with zero upper lane
    start_load();
    drive_byte(8'h13);
    drive_byte(8'h00);
    drive_byte(8'ha0);
    check("t4_we_b2", mem_we, 0);
    end_load();
    check("t4_end_we", mem_we, 0);
    idle();
    check("t4_flush_we", mem_we, 1);
    check("t4_flush_addr", mem_addr, 32'h0);
    check("t4_flush_data", mem_wdata, 32'h00a00013);
    check("t4_flush_ready", ld_ready, 0);
    check("t4_flush_done", ld_done, 0);
    check("t4_flush_stall", core_stall, 1);
    idle();
    check("t4_done", ld_done, 1);
    idle();
    check("t4_mem0", mem[0], 32'h00a00013);
    check("t4_mem1", mem[1], 32'h12345117);

    // 5: fill the whole memory and overrun by two bytes
    zw = zero_writes;
    start_load();
    for (int i = 0; i < 4 * DEPTH + 2; i++) begin
      drive_byte(8'(i));
      exp_we = (i < 4 * DEPTH) && (i % 4 == 3);
      check("t5_we", mem_we, 32'(exp_we));
      if (exp_we) check("t5_addr", mem_addr, 32'(i & ~3));
      if (i == 4 * DEPTH) begin
        check("t5_done", ld_done, 1);
        check("t5_ready_done", ld_ready, 0);
      end
      if (i == 4 * DEPTH + 1) begin
        check("t5_ready_run", ld_ready, 0);
        check("t5_stall_run", core_stall, 0);
      end
    end
    idle();
    check("t5_zero_writes", 32'(zero_writes - zw), 1);
    check("t5_mem31", mem[31], 32'h7f7e7d7c);
    check("t5_mem0", mem[0], 32'h03020100);

    // 6: reset in the middle of the second word
    start_load();
    for (int i = 0; i < 6; i++) begin
      drive_byte(8'ha0 + 8'(i));
      if (i == 3) check("t6_data_w0", mem_wdata, 32'ha3a2a1a0);
    end
    @(negedge clk);
    rst = 1'b1; ld_byte = 8'ha6;
    #1;
    check("t6_rst_stall", core_stall, 0);
    check("t6_rst_ready", ld_ready, 0);
    check("t6_rst_we", mem_we, 0);
    @(negedge clk);
    rst = 1'b0; ld_byte_valid = 1'b0;
    #1;
    check("t6_stall_run", core_stall, 0);
    check("t6_mem0", mem[0], 32'ha3a2a1a0);
    check("t6_mem1", mem[1], 32'h07060504);
    start_load();
    drive_byte(8'hc0);
    drive_byte(8'hc1);
    drive_byte(8'hc2);
    drive_byte(8'hc3);
    check("t6_restart_we", mem_we, 1);
    check("t6_restart_addr", mem_addr, 32'h0);
    end_load();
    idle();
    check("t6_done", ld_done, 1);
    fetch(32'h0);
    @(posedge clk); #1;
    check("t6_fetch", fetch_inst, 32'hc3c2c1c0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
